// File: rtl/cpu_pkg.sv
// Shared definitions for the ID/EX pipeline slice.
// Holds the default datapath/index widths, the hardwired-zero register
// index, the ALU operation encodings and the forwarding-select type used
// by the operand muxes.
package cpu_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  // Register 0 is hardwired to zero and must never be a forwarding target.
  localparam logic [RW_DEF-1:0] REG_ZERO = 5'd0;

  // ALU operation encodings (classic MIPS-style control values).
  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_SLT    = 4'b0111;
  localparam logic [3:0] ALU_NOR    = 4'b1100;
  // A bubble carries the all-zero operation code.
  localparam logic [3:0] ALU_BUBBLE = 4'b0000;

  // Which source an operand mux hands to the ALU.
  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_if.sv
// Bundle of every signal crossing the ID/EX boundary: ID-stage inputs,
// pipeline control (stall/flush), both forwarding sources, and the
// EX-stage outputs toward the ALU, memory stage and hazard unit.
// Modports:
//   master - the surrounding pipeline; drives ID inputs and forwarding.
//   slave  - the id_ex register itself.
interface id_ex_if import cpu_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
);
  logic          id_valid;
  logic [DW-1:0] id_rs_val;
  logic [DW-1:0] id_rt_val;
  logic [DW-1:0] id_imm;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [3:0]    id_aluop;
  logic          id_alusrc;
  logic          id_regwrite;
  logic          id_memread;
  logic          id_memwrite;
  logic          stall;
  logic          flush;
  logic          exmem_regwrite;
  logic [RW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_regwrite;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_result;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [3:0]    ALUop;
  logic [DW-1:0] ex_store_data;
  logic          ex_valid;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;
  logic [RW-1:0] ex_rd;
  logic          load_use;

  modport master (
    output id_valid, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd,
           id_aluop, id_alusrc, id_regwrite, id_memread, id_memwrite,
           stall, flush, exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    input  A, B, ALUop, ex_store_data, ex_valid, ex_regwrite, ex_memread,
           ex_memwrite, ex_rd, load_use
  );

  modport slave (
    input  id_valid, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd,
           id_aluop, id_alusrc, id_regwrite, id_memread, id_memwrite,
           stall, flush, exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    output A, B, ALUop, ex_store_data, ex_valid, ex_regwrite, ex_memread,
           ex_memwrite, ex_rd, load_use
  );
endinterface

// File: rtl/id_ex_fwd_mux.sv
// Operand forwarding mux for one source register.
// Ports:
//   i_idx            - registered source index held in EX
//   i_reg_val        - registered operand value held in EX
//   i_exmem_*        - EX/MEM writeback candidate (highest priority)
//   i_memwb_*        - MEM/WB writeback candidate
//   o_val            - operand after forwarding
module fwd_mux import cpu_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] i_idx,
  input  logic [DW-1:0] i_reg_val,
  input  logic          i_exmem_regwrite,
  input  logic [RW-1:0] i_exmem_rd,
  input  logic [DW-1:0] i_exmem_result,
  input  logic          i_memwb_regwrite,
  input  logic [RW-1:0] i_memwb_rd,
  input  logic [DW-1:0] i_memwb_result,
  output logic [DW-1:0] o_val
);

  logic     w_idx_nz;
  fwd_sel_e w_sel;

  assign w_idx_nz = (i_idx != RW'(REG_ZERO));

  // Pick the youngest in-flight producer of this register; the older
  // stage only wins when the younger one does not match.
  always_comb begin
    w_sel = FWD_REG;
    if (w_idx_nz && i_exmem_regwrite && (i_exmem_rd == i_idx)) begin
      w_sel = FWD_EXMEM;
    end else if (w_idx_nz && i_memwb_regwrite && (i_memwb_rd == i_idx)) begin
      w_sel = FWD_MEMWB;
    end else begin
      w_sel = FWD_REG;
    end
  end

  // Route the selected source to the operand.
  always_comb begin
    o_val = i_reg_val;
    case (w_sel)
      FWD_EXMEM: o_val = i_exmem_result;
      FWD_MEMWB: o_val = i_memwb_result;
      FWD_REG:   o_val = i_reg_val;
      default:   o_val = i_reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears every register
//   bus   - id_ex_if.slave: ID inputs, stall/flush, forwarding sources,
//           ALU operands, registered controls and the load_use request
// Priority at each edge: reset > flush > stall > normal load.
module id_ex import cpu_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic     clk,
  input  logic     reset,
  id_ex_if.slave   bus
);

  logic          r_valid;
  logic          r_regwrite;
  logic          r_memread;
  logic          r_memwrite;
  logic          r_alusrc;
  logic [3:0]    r_aluop;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic [RW-1:0] r_rd;
  logic [DW-1:0] r_rs_val;
  logic [DW-1:0] r_rt_val;
  logic [DW-1:0] r_imm;

  logic [DW-1:0] w_rs_fwd;
  logic [DW-1:0] w_rt_fwd;
  logic [DW-1:0] w_b;
  logic          w_load_use;

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .i_idx            (r_rs),
    .i_reg_val        (r_rs_val),
    .i_exmem_regwrite (bus.exmem_regwrite),
    .i_exmem_rd       (bus.exmem_rd),
    .i_exmem_result   (bus.exmem_result),
    .i_memwb_regwrite (bus.memwb_regwrite),
    .i_memwb_rd       (bus.memwb_rd),
    .i_memwb_result   (bus.memwb_result),
    .o_val            (w_rs_fwd)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .i_idx            (r_rt),
    .i_reg_val        (r_rt_val),
    .i_exmem_regwrite (bus.exmem_regwrite),
    .i_exmem_rd       (bus.exmem_rd),
    .i_exmem_result   (bus.exmem_result),
    .i_memwb_regwrite (bus.memwb_regwrite),
    .i_memwb_rd       (bus.memwb_rd),
    .i_memwb_result   (bus.memwb_result),
    .o_val            (w_rt_fwd)
  );

  // EX-stage register. A flush only kills the controls (data is left as
  // is since a bubble never uses it). A stall re-captures the forwarded
  // operands so a producer retiring during the stall is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_aluop    <= ALU_BUBBLE;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_rs_val   <= '0;
      r_rt_val   <= '0;
      r_imm      <= '0;
    end else if (bus.flush) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_aluop    <= ALU_BUBBLE;
    end else if (bus.stall) begin
      r_rs_val   <= w_rs_fwd;
      r_rt_val   <= w_rt_fwd;
    end else begin
      r_valid    <= bus.id_valid;
      r_regwrite <= bus.id_regwrite;
      r_memread  <= bus.id_memread;
      r_memwrite <= bus.id_memwrite;
      r_alusrc   <= bus.id_alusrc;
      r_aluop    <= bus.id_aluop;
      r_rs       <= bus.id_rs;
      r_rt       <= bus.id_rt;
      r_rd       <= bus.id_rd;
      r_rs_val   <= bus.id_rs_val;
      r_rt_val   <= bus.id_rt_val;
      r_imm      <= bus.id_imm;
    end
  end

  // Second ALU operand: immediate or forwarded rt.
  always_comb begin
    w_b = w_rt_fwd;
    if (r_alusrc) begin
      w_b = r_imm;
    end else begin
      w_b = w_rt_fwd;
    end
  end

  // A load in EX whose destination is read by the instruction in ID
  // cannot be forwarded in time, so request a stall.
  always_comb begin
    w_load_use = 1'b0;
    if (r_valid && r_memread && (r_rd != RW'(REG_ZERO)) && bus.id_valid &&
        ((r_rd == bus.id_rs) || (r_rd == bus.id_rt))) begin
      w_load_use = 1'b1;
    end else begin
      w_load_use = 1'b0;
    end
  end

  assign bus.A             = w_rs_fwd;
  assign bus.B             = w_b;
  assign bus.ALUop         = r_aluop;
  assign bus.ex_store_data = w_rt_fwd;
  assign bus.ex_valid      = r_valid;
  assign bus.ex_regwrite   = r_regwrite;
  assign bus.ex_memread    = r_memread;
  assign bus.ex_memwrite   = r_memwrite;
  assign bus.ex_rd         = r_rd;
  assign bus.load_use      = w_load_use;

endmodule

// File: tb/tb_id_ex.sv
// Self-checking bench for id_ex: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the EX slot.
module tb_id_ex import cpu_pkg::*;;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        alusrc;
    logic [3:0]  aluop;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
  } instr_t;

  logic   clk;
  logic   rst;
  int     n_cmp;
  int     n_mis;
  instr_t id_cur;
  instr_t m;       // model of the instruction currently in EX
  bit     m_known; // data fields meaningful (false after a flush)

  id_ex_if #(.DW(32), .RW(5)) bus ();

  id_ex #(.DW(32), .RW(5)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Value a register read in EX should see right now.
  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] held);
    if (idx != 5'd0 && bus.exmem_regwrite && bus.exmem_rd == idx) return bus.exmem_result;
    if (idx != 5'd0 && bus.memwb_regwrite && bus.memwb_rd == idx) return bus.memwb_result;
    return held;
  endfunction

  task automatic apply_id(input instr_t x);
    id_cur          = x;
    bus.id_valid    = x.valid;
    bus.id_regwrite = x.regwrite;
    bus.id_memread  = x.memread;
    bus.id_memwrite = x.memwrite;
    bus.id_alusrc   = x.alusrc;
    bus.id_aluop    = x.aluop;
    bus.id_rs       = x.rs;
    bus.id_rt       = x.rt;
    bus.id_rd       = x.rd;
    bus.id_rs_val   = x.rs_val;
    bus.id_rt_val   = x.rt_val;
    bus.id_imm      = x.imm;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exmem_regwrite = ew;
    bus.exmem_rd       = erd;
    bus.exmem_result   = eres;
    bus.memwb_regwrite = mw;
    bus.memwb_rd       = mrd;
    bus.memwb_result   = mres;
  endtask

  function automatic instr_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] rsv,
                                input logic [31:0] rtv, input logic mr);
    instr_t x;
    x = '0;
    x.valid = v; x.rs = rs; x.rt = rt; x.rd = rd;
    x.rs_val = rsv; x.rt_val = rtv; x.imm = 32'h0000_0100;
    x.aluop = ALU_ADD; x.regwrite = 1'b1; x.memread = mr;
    return x;
  endfunction

  function automatic instr_t rand_instr();
    instr_t x;
    x.valid    = 1'($urandom_range(0, 3) != 0);
    x.regwrite = 1'($urandom_range(0, 1));
    x.memread  = 1'($urandom_range(0, 2) == 0);
    x.memwrite = 1'($urandom_range(0, 3) == 0);
    x.alusrc   = 1'($urandom_range(0, 1));
    x.aluop    = 4'($urandom_range(0, 15));
    x.rs       = 5'($urandom_range(0, 7));
    x.rt       = 5'($urandom_range(0, 7));
    x.rd       = 5'($urandom_range(0, 7));
    x.rs_val   = $urandom;
    x.rt_val   = $urandom;
    x.imm      = $urandom;
    return x;
  endfunction

  // Compare every output against the model.
  task automatic check_all();
    logic lu;
    lu = m.valid && m.memread && (m.rd != 5'd0) && id_cur.valid &&
         ((m.rd == id_cur.rs) || (m.rd == id_cur.rt));
    check("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m.valid});
    check("ex_regwrite", {31'd0, bus.ex_regwrite}, {31'd0, m.regwrite});
    check("ex_memread", {31'd0, bus.ex_memread}, {31'd0, m.memread});
    check("ex_memwrite", {31'd0, bus.ex_memwrite}, {31'd0, m.memwrite});
    check("ALUop", {28'd0, bus.ALUop}, {28'd0, m.aluop});
    check("load_use", {31'd0, bus.load_use}, {31'd0, lu});
    if (m_known) begin
      check("A", bus.A, fwd(m.rs, m.rs_val));
      check("B", bus.B, m.alusrc ? m.imm : fwd(m.rt, m.rt_val));
      check("store_data", bus.ex_store_data, fwd(m.rt, m.rt_val));
      check("ex_rd", {27'd0, bus.ex_rd}, {27'd0, m.rd});
    end
  endtask

  // Advance the model by one clock edge using the inputs present at it.
  task automatic update_model();
    if (rst) begin
      m = '0;
      m_known = 1'b1;
    end else if (bus.flush) begin
      m.valid = 1'b0; m.regwrite = 1'b0; m.memread = 1'b0; m.memwrite = 1'b0;
      m.aluop = 4'b0000;
      m_known = 1'b0;
    end else if (bus.stall) begin
      m.rs_val = fwd(m.rs, m.rs_val);
      m.rt_val = fwd(m.rt, m.rt_val);
    end else begin
      m = id_cur;
      m_known = 1'b1;
    end
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    m = '0;
    m_known = 1'b0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    apply_id('0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Reset state
    @(posedge clk);
    update_model();
    #1;
    rst = 1'b0;

    // Basic load
    apply_id(mk(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0));
    tick();
    check("basic_A", bus.A, 32'd5);
    check("basic_B", bus.B, 32'd7);
    check("basic_ALUop", {28'd0, bus.ALUop}, 32'd2);

    // Both forwarding sources match: EX/MEM wins
    apply_id(mk(1'b1, 5'd3, 5'd2, 5'd5, 32'h0000_0AAA, 32'd1, 1'b0));
    tick();
    set_fwd(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    #1;
    check("dual_fwd_A", bus.A, 32'h11);

    // Index 0 is never forwarded
    apply_id(mk(1'b1, 5'd0, 5'd2, 5'd5, 32'h0000_1234, 32'd1, 1'b0));
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    set_fwd(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0);
    #1;
    check("zero_idx_A", bus.A, 32'h0000_1234);

    // Load-use
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    apply_id(mk(1'b1, 5'd1, 5'd2, 5'd4, 32'd0, 32'd0, 1'b1));
    tick();
    apply_id(mk(1'b1, 5'd9, 5'd4, 5'd6, 32'd0, 32'd0, 1'b0));
    #1;
    check("load_use_hit", {31'd0, bus.load_use}, 32'd1);

    // Stall with a writeback in its first cycle, then flush+stall
    apply_id(mk(1'b1, 5'd6, 5'd2, 5'd7, 32'h10, 32'd3, 1'b0));
    tick();
    bus.stall = 1'b1;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h55);
    #1;
    check("stall1_A", bus.A, 32'h55);
    tick();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    check("stall2_A", bus.A, 32'h55);
    tick();
    bus.flush = 1'b1;
    tick();
    check("bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("bubble_ALUop", {28'd0, bus.ALUop}, 32'd0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // Mid-stream reset
    apply_id(mk(1'b1, 5'd4, 5'd4, 5'd4, 32'h77, 32'h88, 1'b1));
    tick();
    check("pre_reset_valid", {31'd0, bus.ex_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_A", bus.A, 32'd0);
    check("rst_B", bus.B, 32'd0);
    check("rst_ALUop", {28'd0, bus.ALUop}, 32'd0);
    check("rst_store", bus.ex_store_data, 32'd0);
    check("rst_rd", {27'd0, bus.ex_rd}, 32'd0);
    check("rst_ctrl", {28'd0, bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite}, 32'd0);
    check("rst_load_use", {31'd0, bus.load_use}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      apply_id(rand_instr());
      set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      bus.stall = 1'($urandom_range(0, 4) == 0);
      bus.flush = 1'($urandom_range(0, 7) == 0);
      rst       = 1'($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
